// File: rtl/feature_wb_agu.sv
// Write-back address generator: maps pooled (h, w, channel-group) beats to feature BRAM
// word addresses, re-aligns lagging pool data, counts writes and flags out-of-range beats.
module feature_wb_agu #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int DIM_WIDTH  = 8,
  parameter int DATA_LAG   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          layer_start,
  input  logic [DIM_WIDTH-1:0]          cfg_out_size,
  input  logic [DIM_WIDTH-1:0]          cfg_out_channel,
  input  logic                          cfg_dst_bank,
  input  logic [ADDR_WIDTH-1:0]         bank_base0,
  input  logic [ADDR_WIDTH-1:0]         bank_base1,
  input  logic                          in_valid,
  input  logic [DIM_WIDTH-1:0]          in_h,
  input  logic [DIM_WIDTH-1:0]          in_w,
  input  logic [DIM_WIDTH-1:0]          in_ch,
  input  logic [DATA_WIDTH*LANES-1:0]   in_data,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH*LANES-1:0]   wr_data,
  output logic                          busy,
  output logic                          layer_done,
  output logic                          err_oob
);

  localparam int LOG2_LANES = $clog2(LANES);
  localparam int WORD_W     = DATA_WIDTH * LANES;
  localparam int ROW_W      = 2 * DIM_WIDTH;
  localparam int CNT_W      = 3 * DIM_WIDTH;
  localparam int SUM_W      = ADDR_WIDTH + CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DIM_WIDTH-1:0]    s_q, s_d, c_q, c_d, cw_q, cw_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [CNT_W-1:0]        total_q, total_d, cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]       wr_data_q, wr_data_d;

  logic [DIM_WIDTH-1:0]    cw_calc;
  logic [ROW_W-1:0]        row_calc;
  logic [CNT_W-1:0]        total_calc;
  logic [SUM_W-1:0]        addr_sum;
  logic                    beat_vld, beat_oob, tail_vld, tail_oob;
  logic [ADDR_WIDTH-1:0]   beat_addr, tail_addr;

  // Layer geometry derived from the latched size/channel count
  always_comb begin
    cw_calc    = DIM_WIDTH'(({1'b0, c_q} + (DIM_WIDTH+1)'(LANES - 1)) >> LOG2_LANES);
    row_calc   = ROW_W'(s_q) * ROW_W'(cw_calc);
    total_calc = CNT_W'(s_q) * CNT_W'(row_calc);
  end

  always_comb begin
    addr_sum  = SUM_W'(base_q) + SUM_W'(in_h) * SUM_W'(row_q) + SUM_W'(in_w) * SUM_W'(cw_q)
              + SUM_W'(in_ch >> LOG2_LANES);
    beat_addr = addr_sum[ADDR_WIDTH-1:0];
    beat_vld  = (state_q == S_RUN) && in_valid && !layer_start;
    beat_oob  = (in_h >= s_q) || (in_w >= s_q) || (in_ch >= c_q)
              || ((in_ch & DIM_WIDTH'(LANES - 1)) != '0);
  end

  // Delay line carrying address/error of each beat until its data arrives
  generate
    if (DATA_LAG == 0) begin : g_nolag
      assign tail_vld  = beat_vld;
      assign tail_oob  = beat_oob;
      assign tail_addr = beat_addr;
    end else begin : g_lag
      logic                  stg_vld_q  [1:DATA_LAG];
      logic                  stg_vld_d  [1:DATA_LAG];
      logic                  stg_oob_q  [1:DATA_LAG];
      logic                  stg_oob_d  [1:DATA_LAG];
      logic [ADDR_WIDTH-1:0] stg_addr_q [1:DATA_LAG];
      logic [ADDR_WIDTH-1:0] stg_addr_d [1:DATA_LAG];

      always_comb begin
        stg_vld_d[1]  = beat_vld;
        stg_oob_d[1]  = beat_oob;
        stg_addr_d[1] = beat_addr;
        for (int i = 2; i <= DATA_LAG; i++) begin
          stg_vld_d[i]  = stg_vld_q[i-1];
          stg_oob_d[i]  = stg_oob_q[i-1];
          stg_addr_d[i] = stg_addr_q[i-1];
        end
        if (layer_start) begin
          for (int i = 1; i <= DATA_LAG; i++) stg_vld_d[i] = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 1; i <= DATA_LAG; i++) begin
            stg_vld_q[i]  <= 1'b0;
            stg_oob_q[i]  <= 1'b0;
            stg_addr_q[i] <= '0;
          end
        end else begin
          stg_vld_q  <= stg_vld_d;
          stg_oob_q  <= stg_oob_d;
          stg_addr_q <= stg_addr_d;
        end
      end

      assign tail_vld  = stg_vld_q[DATA_LAG];
      assign tail_oob  = stg_oob_q[DATA_LAG];
      assign tail_addr = stg_addr_q[DATA_LAG];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    base_d    = base_q;
    cw_d      = cw_q;
    row_d     = row_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    if (tail_vld) begin
      if (tail_oob) begin
        err_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = tail_addr;
        wr_data_d = in_data;
      end
    end

    case (state_q)
      S_CFG: begin
        cw_d    = cw_calc;
        row_d   = row_calc;
        total_d = total_calc;
        state_d = (total_calc == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (wr_en_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == total_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    // A new layer aborts anything in flight, including the beat about to be written
    if (layer_start) begin
      state_d   = S_CFG;
      s_d       = cfg_out_size;
      c_d       = cfg_out_channel;
      base_d    = cfg_dst_bank ? bank_base1 : bank_base0;
      cnt_d     = '0;
      err_d     = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      c_q       <= '0;
      base_q    <= '0;
      cw_q      <= '0;
      row_q     <= '0;
      total_q   <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      base_q    <= base_d;
      cw_q      <= cw_d;
      row_q     <= row_d;
      total_q   <= total_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign err_oob    = err_q;
  assign busy       = (state_q == S_CFG) || (state_q == S_RUN);
  assign layer_done = (state_q == S_DONE);

endmodule

// File: tb/tb_feature_wb_agu.sv
// Directed bench for feature_wb_agu: vector table for single beats plus hand-written
// sequences for raster streaming, abort, reset in RUN and the empty layer.
module tb_feature_wb_agu;

  localparam int DW = 8, LN = 8, AW = 12, DM = 8, LAG = 2;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic           clk = 1'b0;
  logic           rst, layer_start, cfg_dst_bank, in_valid;
  logic [DM-1:0]  cfg_out_size, cfg_out_channel, in_h, in_w, in_ch;
  logic [AW-1:0]  bank_base0, bank_base1, wr_addr;
  logic [DW*LN-1:0] in_data, wr_data;
  logic           wr_en, busy, layer_done, err_oob;

  int checks = 0;
  int errors = 0;

  feature_wb_agu #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW), .DIM_WIDTH(DM), .DATA_LAG(LAG)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start),
    .cfg_out_size(cfg_out_size), .cfg_out_channel(cfg_out_channel), .cfg_dst_bank(cfg_dst_bank),
    .bank_base0(bank_base0), .bank_base1(bank_base1),
    .in_valid(in_valid), .in_h(in_h), .in_w(in_w), .in_ch(in_ch), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .layer_done(layer_done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int t);
    logic [7:0] b;
    b = 8'(t);
    return {8{b}};
  endfunction

  task automatic start_layer(input logic [7:0] s, input logic [7:0] c, input logic dst);
    cfg_out_size = s; cfg_out_channel = c; cfg_dst_bank = dst;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    cfg_out_size = 8'hFF; cfg_out_channel = 8'hFF; cfg_dst_bank = ~dst;
    chk("cfg_busy", 64'(busy), 64'(1'b1));
    tick();
  endtask

  typedef struct {
    logic [7:0]  h, w, ch;
    logic [63:0] data;
    logic        we;
    logic [11:0] addr;
    logic        err;
  } vec_t;

  vec_t vecs [10];
  logic [63:0] last_data;
  logic [11:0] last_addr;
  logic        prev_err;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // S=2, C=12 -> CW=2, ROW=4, TOTAL=8, base 0x100
    vecs[0] = '{8'd1, 8'd1, 8'd8, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 12'h107, 1'b0};
    vecs[1] = '{8'd0, 8'd0, 8'd0, 64'h1111_2222_3333_4444, 1'b1, 12'h100, 1'b0};
    vecs[2] = '{8'd1, 8'd0, 8'd0, 64'h0123_4567_89AB_CDEF, 1'b1, 12'h104, 1'b0};
    vecs[3] = '{8'd0, 8'd1, 8'd8, 64'hFEDC_BA98_7654_3210, 1'b1, 12'h103, 1'b0};
    vecs[4] = '{8'd1, 8'd1, 8'd0, 64'h5555_AAAA_5555_AAAA, 1'b1, 12'h106, 1'b0};
    vecs[5] = '{8'd0, 8'd2, 8'd0, 64'h9999_9999_9999_9999, 1'b0, 12'h000, 1'b1};
    vecs[6] = '{8'd0, 8'd0, 8'd4, 64'h7777_7777_7777_7777, 1'b0, 12'h000, 1'b1};
    vecs[7] = '{8'd0, 8'd0, 8'd8, 64'hC0DE_0000_0000_0007, 1'b1, 12'h101, 1'b1};
    vecs[8] = '{8'd0, 8'd1, 8'd0, 64'hC0DE_0000_0000_0008, 1'b1, 12'h102, 1'b1};
    vecs[9] = '{8'd1, 8'd0, 8'd8, 64'hC0DE_0000_0000_0009, 1'b1, 12'h105, 1'b1};

    rst = 1'b1; layer_start = 1'b0; in_valid = 1'b0;
    cfg_out_size = '0; cfg_out_channel = '0; cfg_dst_bank = 1'b0;
    bank_base0 = 12'h100; bank_base1 = 12'h400;
    in_h = '0; in_w = '0; in_ch = '0; in_data = JUNK;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wr_en", 64'(wr_en), 64'(1'b0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(12'h0));
    chk("rst_wr_data", wr_data, 64'h0);
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_layer_done", 64'(layer_done), 64'(1'b0));
    chk("rst_err_oob", 64'(err_oob), 64'(1'b0));

    // Isolated beats from the vector table
    start_layer(8'd2, 8'd12, 1'b0);
    last_addr = 12'h0; last_data = 64'h0; prev_err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_h = vecs[i].h; in_w = vecs[i].w; in_ch = vecs[i].ch; in_data = JUNK;
      tick();
      in_valid = 1'b0;
      chk("vec_t1_wr_en", 64'(wr_en), 64'(1'b0));
      tick();
      in_data = vecs[i].data;
      chk("vec_t2_wr_en", 64'(wr_en), 64'(1'b0));
      chk("vec_t2_err", 64'(err_oob), 64'(prev_err));
      tick();
      in_data = JUNK;
      if (vecs[i].we) begin
        last_addr = vecs[i].addr;
        last_data = vecs[i].data;
      end
      chk("vec_wr_en", 64'(wr_en), 64'(vecs[i].we));
      chk("vec_wr_addr", 64'(wr_addr), 64'(last_addr));
      chk("vec_wr_data", wr_data, last_data);
      chk("vec_err_oob", 64'(err_oob), 64'(vecs[i].err));
      chk("vec_layer_done", 64'(layer_done), 64'(1'b0));
      prev_err = vecs[i].err;
      $display("vec %0d: h=%0d w=%0d ch=%0d -> wr_en=%0b addr=%03h err=%0b",
               i, vecs[i].h, vecs[i].w, vecs[i].ch, wr_en, wr_addr, err_oob);
    end
    tick();
    chk("tbl_layer_done", 64'(layer_done), 64'(1'b1));
    chk("tbl_done_busy", 64'(busy), 64'(1'b0));
    chk("tbl_err_sticky", 64'(err_oob), 64'(1'b1));
    tick();
    chk("tbl_done_pulse", 64'(layer_done), 64'(1'b0));

    // Raster stream, S=4 C=64 into bank 1
    start_layer(8'd4, 8'd64, 1'b1);
    chk("raster_err_cleared", 64'(err_oob), 64'(1'b0));
    chk("raster_busy", 64'(busy), 64'(1'b1));
    for (int t = 0; t < 134; t++) begin
      if (t >= 3 && t < 131) begin
        chk("raster_wr_en", 64'(wr_en), 64'(1'b1));
        chk("raster_wr_addr", 64'(wr_addr), 64'(12'h400 + 12'(t - 3)));
        chk("raster_wr_data", wr_data, pat(t - 3));
      end else begin
        chk("raster_wr_en_idle", 64'(wr_en), 64'(1'b0));
      end
      chk("raster_layer_done", 64'(layer_done), 64'(t == 131));
      in_valid = (t < 128);
      in_h = 8'(t / 32); in_w = 8'((t % 32) / 8); in_ch = 8'((t % 8) * 8);
      in_data = (t >= 2 && t < 130) ? pat(t - 2) : JUNK;
      tick();
    end
    $display("raster: 128 beats streamed, last addr=%03h", wr_addr);

    // Abort with two beats in flight
    start_layer(8'd2, 8'd12, 1'b0);
    in_valid = 1'b1; in_h = 8'd0; in_w = 8'd0; in_ch = 8'd0; tick();
    in_ch = 8'd8; tick();
    in_valid = 1'b0; in_data = 64'h0BAD_0BAD_0BAD_0BAD;
    cfg_out_size = 8'd1; cfg_out_channel = 8'd8; cfg_dst_bank = 1'b1; layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("abort_wr_en_a", 64'(wr_en), 64'(1'b0));
    chk("abort_busy", 64'(busy), 64'(1'b1));
    chk("abort_no_done_a", 64'(layer_done), 64'(1'b0));
    tick();
    chk("abort_wr_en_b", 64'(wr_en), 64'(1'b0));
    chk("abort_no_done_b", 64'(layer_done), 64'(1'b0));
    in_valid = 1'b1; in_h = 8'd0; in_w = 8'd0; in_ch = 8'd0; tick();
    in_valid = 1'b0; tick();
    in_data = 64'h1234_5678_9ABC_DEF0; tick();
    in_data = JUNK;
    chk("abort_new_wr_en", 64'(wr_en), 64'(1'b1));
    chk("abort_new_addr", 64'(wr_addr), 64'(12'h400));
    chk("abort_new_data", wr_data, 64'h1234_5678_9ABC_DEF0);
    chk("abort_new_no_done", 64'(layer_done), 64'(1'b0));
    tick();
    chk("abort_new_done", 64'(layer_done), 64'(1'b1));
    tick();
    $display("abort: new layer wrote addr=%03h", wr_addr);

    // Reset while running
    start_layer(8'd2, 8'd12, 1'b0);
    in_valid = 1'b1; in_h = 8'd1; in_w = 8'd1; in_ch = 8'd0; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; in_data = 64'hAAAA_BBBB_CCCC_DDDD;
    chk("rrst_wr_en", 64'(wr_en), 64'(1'b0));
    chk("rrst_wr_addr", 64'(wr_addr), 64'(12'h0));
    chk("rrst_wr_data", wr_data, 64'h0);
    chk("rrst_busy", 64'(busy), 64'(1'b0));
    chk("rrst_layer_done", 64'(layer_done), 64'(1'b0));
    chk("rrst_err_oob", 64'(err_oob), 64'(1'b0));
    tick();
    chk("rrst_no_write", 64'(wr_en), 64'(1'b0));
    in_valid = 1'b1; in_h = 8'd0; in_w = 8'd5; in_ch = 8'd0; tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("idle_beat_wr_en", 64'(wr_en), 64'(1'b0));
      chk("idle_beat_err", 64'(err_oob), 64'(1'b0));
      tick();
    end
    $display("reset in RUN: outputs cleared, idle beat ignored");

    // Empty layer S=0
    cfg_out_size = 8'd0; cfg_out_channel = 8'd8; cfg_dst_bank = 1'b0; layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("s0_cfg_done", 64'(layer_done), 64'(1'b0));
    chk("s0_cfg_busy", 64'(busy), 64'(1'b1));
    tick();
    chk("s0_layer_done", 64'(layer_done), 64'(1'b1));
    chk("s0_wr_en", 64'(wr_en), 64'(1'b0));
    chk("s0_busy", 64'(busy), 64'(1'b0));
    tick();
    chk("s0_done_pulse", 64'(layer_done), 64'(1'b0));
    chk("s0_wr_en_after", 64'(wr_en), 64'(1'b0));
    $display("empty layer: layer_done pulse seen");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
